pd_switch_sequencer: RTL and testbench
======================================

# pd_switch_sequencer

- Per-domain power-switch sequencer driven by one `power` request bit from the PMU wakeup-counter FSM.
- Orders switch enable, clock enable, reset release and isolation release on power-up, and the reverse on power-down.
- Handshakes with the domain's daisy-chained switch ring through `sleep_send_o`/`sleep_ack_i`.
- Returns a settled `done_o` level that the PMU FSM waits on before stepping to the next domain.
- One instance per gated domain: LOGIC, L2, L2_UDMA, L1, UDMA.

## Interface
Parameters:
- `ACK_TIMEOUT`, 64: max cycles to wait for ring echo before forcing progress.
- `RST_DELAY`, 4: cycles clock runs with domain reset still asserted on power-up.
- `ISO_DELAY`, 2: cycles between reset release and isolation release (up), and between isolation assert and switch-off (down).

Ports:
- `clk_i`, in, 1: 32.768 kHz reference clock. One clock; reset is synchronous and active-low.
- `rstn_i`, in, 1: synchronous active-low reset.
- `power_i`, in, 1: 1 = domain requested on; 0 = off.
- `sleep_ack_i`, in, 1: ring echo of `sleep_send_o`; asynchronous.
- `sleep_send_o`, out, 1: 1 = switches open (domain unpowered).
- `isolate_o`, out, 1: 1 = domain outputs clamped.
- `clk_en_o`, out, 1: domain clock gate enable.
- `rstn_pd_o`, out, 1: active-low domain reset.
- `done_o`, out, 1: domain settled in the state requested by `power_i`.
- `timeout_o`, out, 1: sticky flag; an ack wait expired.

## Operation
States: OFF, PWR_UP, CLK_ON, RST_REL, ON, ISO_ON, PWR_DN. All outputs are registered and decoded from next state.

- **Reset**
  - State OFF.
  - Outputs: `sleep_send_o`=1, `isolate_o`=1, `clk_en_o`=0, `rstn_pd_o`=0, `done_o`=0, `timeout_o`=0.
  - Ack synchronizer flops reset to 1.
- **OFF**
  - `power_i`=1 → PWR_UP.
  - Otherwise stay, with `done_o`=1.
- **PWR_UP**
  - `sleep_send_o`=0.
  - Wait for synchronized ack = 0, then → CLK_ON.
- **CLK_ON**
  - `clk_en_o`=1, reset still asserted.
  - After `RST_DELAY` cycles → RST_REL.
- **RST_REL**
  - `rstn_pd_o`=1.
  - After `ISO_DELAY` cycles → ON.
- **ON**
  - `isolate_o`=0, `done_o`=1 while `power_i`=1.
  - `power_i`=0 → ISO_ON.
- **ISO_ON**
  - `isolate_o`=1, `done_o`=0.
  - After `ISO_DELAY` cycles → PWR_DN.
- **PWR_DN**
  - In the same cycle: `clk_en_o`=0, `rstn_pd_o`=0, `sleep_send_o`=1.
  - Wait for synchronized ack = 1, then → OFF.
- **`done_o` rule:** `done_o` = (state OFF and `power_i`=0) or (state ON and `power_i`=1). It is 0 in every transitional state.
- **No abort:** a started sequence always completes to its end state. A `power_i` change mid-sequence is acted on only from OFF or ON.
- **Counter:** one shared down-counter, width `$clog2(max(ACK_TIMEOUT, RST_DELAY, ISO_DELAY)+1)`. Loaded on state entry; no wrap.
- **Reset mid-sequence:** returns to OFF and the reset values at the next edge, whatever the state. Switch-off and isolation occur in the same cycle.

## Timing
Edge 0 is the edge that samples the request.

- **Power-up, instant ring:**
  - Edge 0 samples `power_i`=1: `sleep_send_o` falls.
  - Ack passes through the 2-flop sync, so the FSM sees it at edge 3: `clk_en_o`=1.
  - Edge 3+`RST_DELAY`: `rstn_pd_o`=1.
  - Edge 3+`RST_DELAY`+`ISO_DELAY`: `isolate_o`=0, `done_o`=1 (edge 9 with defaults).
- **Power-down:**
  - Edge 0 samples `power_i`=0: `isolate_o`=1, `done_o`=0.
  - Edge `ISO_DELAY`: clock off, reset on, switches open.
  - Edge `ISO_DELAY`+3: OFF, `done_o`=1 (edge 5 with defaults).
- **Ack wait (PWR_UP, PWR_DN):**
  - If no ack within `ACK_TIMEOUT` cycles of state entry, leave the state at edge `ACK_TIMEOUT` after entry.
  - `timeout_o` sets at that edge and holds until reset.
  - An ack seen at the same edge as expiry counts as an ack; no timeout is flagged.

## Configuration
- `PD_ACK_TIMEOUT_EN` defined: timeout counter active as above.
- Undefined:
  - Ack states wait indefinitely.
  - `timeout_o` tied 0.
  - `ACK_TIMEOUT` unused; counter width ignores it.

## Structure
- Package `pd_seq_pkg` holds:
  - `pd_seq_state_e` enum typedef;
  - default constants `PD_ACK_TIMEOUT_DEF`, `PD_RST_DELAY_DEF`, `PD_ISO_DELAY_DEF`.
- Sub-module `pd_ack_sync`: 2-flop synchronizer for `sleep_ack_i`, parameterised reset value (1).

## Test plan
- **Reset then `power_i`=1, ring echo instant, defaults:**
  - Required: `sleep_send_o`↓ at edge 0, `clk_en_o`↑ at edge 3, `rstn_pd_o`↑ at edge 7, `isolate_o`↓ and `done_o`↑ at edge 9.
- **From ON, `power_i`=0:**
  - Required: `isolate_o`↑ at edge 0; `clk_en_o`↓, `rstn_pd_o`↓, `sleep_send_o`↑ at edge 2; `done_o`↑ at edge 5.
- **Ack stuck at 1, `power_i`=1, `PD_ACK_TIMEOUT_EN` set:**
  - Required: CLK_ON entered at edge 64, `timeout_o`=1 and held through a later full power-down.
- **Toggle `power_i` 1→0 one cycle after the power-up request:**
  - Required: power-up completes to ON (`isolate_o`=0); `done_o` stays 0; ISO_ON entered on the next edge.
- **Assert `rstn_i`=0 for 1 cycle while in RST_REL:**
  - Required: at the next edge all outputs take reset values; with `power_i`=1 held, a fresh power-up sequence follows.
- **`PD_ACK_TIMEOUT_EN` undefined, ack stuck at 1 for 1000 cycles:**
  - Required: remains in PWR_UP, `timeout_o`=0; releasing ack to 0 resumes the sequence 3 edges later.

Source files
------------

// File: rtl/pd_seq_pkg.sv
// Shared types and defaults for the per-domain power-switch sequencer:
// FSM state encoding, the registered output bundle and its state decode.
package pd_seq_pkg;

  localparam int PD_ACK_TIMEOUT_DEF = 64;
  localparam int PD_RST_DELAY_DEF   = 4;
  localparam int PD_ISO_DELAY_DEF   = 2;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWR_UP,
    ST_CLK_ON,
    ST_RST_REL,
    ST_ON,
    ST_ISO_ON,
    ST_PWR_DN
  } pd_seq_state_e;

  typedef struct packed {
    logic sleep_send;
    logic isolate;
    logic clk_en;
    logic rstn_pd;
  } pd_seq_out_t;

  localparam pd_seq_out_t PD_OUT_RESET = '{sleep_send: 1'b1, isolate: 1'b1,
                                           clk_en: 1'b0, rstn_pd: 1'b0};

  // Domain control levels that hold while the FSM sits in a given state.
  function automatic pd_seq_out_t pd_seq_decode(input pd_seq_state_e st);
    pd_seq_out_t o;
    o = PD_OUT_RESET;
    case (st)
      ST_PWR_UP:  o.sleep_send = 1'b0;
      ST_CLK_ON:  begin o.sleep_send = 1'b0; o.clk_en = 1'b1; end
      ST_RST_REL,
      ST_ISO_ON:  begin o.sleep_send = 1'b0; o.clk_en = 1'b1; o.rstn_pd = 1'b1; end
      ST_ON:      begin o.sleep_send = 1'b0; o.isolate = 1'b0; o.clk_en = 1'b1; o.rstn_pd = 1'b1; end
      default:    o = PD_OUT_RESET;
    endcase
    return o;
  endfunction

  function automatic int pd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pd_ack_sync.sv
// Two-flop synchronizer for the switch-ring echo; both flops reset to RST_VAL
// so the FSM starts out seeing the ring in the state that matches reset.
module pd_ack_sync
  #(parameter logic RST_VAL = 1'b1)
  (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic sync_o
  );

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pd_switch_sequencer.sv
// Per-domain power-switch sequencer: orders switch, clock, reset and isolation
// on power-up/down. Define PD_ACK_TIMEOUT_EN to bound the ring-ack waits.
module pd_switch_sequencer
  import pd_seq_pkg::*;
  #(
    parameter int ACK_TIMEOUT = PD_ACK_TIMEOUT_DEF,
    parameter int RST_DELAY   = PD_RST_DELAY_DEF,
    parameter int ISO_DELAY   = PD_ISO_DELAY_DEF
  )
  (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic power_i,
    input  logic sleep_ack_i,
    output logic sleep_send_o,
    output logic isolate_o,
    output logic clk_en_o,
    output logic rstn_pd_o,
    output logic done_o,
    output logic timeout_o
  );

`ifdef PD_ACK_TIMEOUT_EN
  localparam int CNT_MAX = pd_max(ACK_TIMEOUT, pd_max(RST_DELAY, ISO_DELAY));
`else
  localparam int CNT_MAX = pd_max(RST_DELAY, ISO_DELAY);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  // Loaded with N-1 on entry so the state is left exactly N edges later.
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_DELAY - 1);
`ifdef PD_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

  pd_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pd_seq_out_t      out_q, out_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             ack_sync;
  logic             cnt_zero;

  pd_ack_sync #(.RST_VAL(1'b1)) u_ack_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (sleep_ack_i),
    .sync_o  (ack_sync)
  );

  assign cnt_zero = (cnt_q == '0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_OFF:     if (power_i) state_d = ST_PWR_UP;
      ST_PWR_UP: begin
        if (!ack_sync) state_d = ST_CLK_ON;
`ifdef PD_ACK_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d   = ST_CLK_ON;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
`endif
      end
      ST_CLK_ON:  if (cnt_zero) state_d = ST_RST_REL; else cnt_d = cnt_q - 1'b1;
      ST_RST_REL: if (cnt_zero) state_d = ST_ON;      else cnt_d = cnt_q - 1'b1;
      ST_ON:      if (!power_i) state_d = ST_ISO_ON;
      ST_ISO_ON:  if (cnt_zero) state_d = ST_PWR_DN;  else cnt_d = cnt_q - 1'b1;
      ST_PWR_DN: begin
        if (ack_sync) state_d = ST_OFF;
`ifdef PD_ACK_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d   = ST_OFF;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
`endif
      end
      default:    state_d = ST_OFF;
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        ST_CLK_ON:             cnt_d = RST_LOAD;
        ST_RST_REL, ST_ISO_ON: cnt_d = ISO_LOAD;
`ifdef PD_ACK_TIMEOUT_EN
        ST_PWR_UP, ST_PWR_DN:  cnt_d = ACK_LOAD;
`endif
        default:               cnt_d = '0;
      endcase
    end

    out_d  = pd_seq_decode(state_d);
    done_d = ((state_d == ST_OFF) && !power_i) || ((state_d == ST_ON) && power_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      out_q     <= PD_OUT_RESET;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign sleep_send_o = out_q.sleep_send;
  assign isolate_o    = out_q.isolate;
  assign clk_en_o     = out_q.clk_en;
  assign rstn_pd_o    = out_q.rstn_pd;
  assign done_o       = done_q;
`ifdef PD_ACK_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pd_switch_sequencer.sv
// Scoreboard bench: stimulus queues the expected output vector and edge for
// each change; a negedge monitor pops and compares whenever the outputs move.
module tb_pd_switch_sequencer;

  logic clk = 1'b0;
  logic rstn;
  logic power;
  logic ack_force_en;
  logic ack_force_val;
  logic sleep_ack;
  logic sleep_send, isolate, clk_en, rstn_pd, done, timeout;

  always #5 clk = ~clk;

  // Ring echo is instant unless the bench forces it.
  assign sleep_ack = ack_force_en ? ack_force_val : sleep_send;

  pd_switch_sequencer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .power_i      (power),
    .sleep_ack_i  (sleep_ack),
    .sleep_send_o (sleep_send),
    .isolate_o    (isolate),
    .clk_en_o     (clk_en),
    .rstn_pd_o    (rstn_pd),
    .done_o       (done),
    .timeout_o    (timeout)
  );

  // Vector order: {sleep_send, isolate, clk_en, rstn_pd, done, timeout}
  logic [5:0] vec;
  assign vec = {sleep_send, isolate, clk_en, rstn_pd, done, timeout};

  typedef struct {
    string      name;
    int         edge_n;
    logic [5:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [5:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input string name, input int edge_n, input logic [5:0] v);
    exp_t e;
    e.name   = name;
    e.edge_n = edge_n;
    e.vec    = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && (vec !== prev)) begin
      if (sb.size() == 0) begin
        check("unexpected_change", {26'd0, vec}, {26'd0, prev});
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_edge"}, cyc, e.edge_n);
        check({e.name, "_val"}, {26'd0, vec}, {26'd0, e.vec});
      end
    end
    prev = vec;
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_power(input logic p, output int e0);
    @(negedge clk);
    power = p;
    e0 = cyc + 1;
  endtask

  task automatic expect_power_down(input string tag, input int e, input logic t);
    push({tag, "_iso"}, e,     {5'b01110, t});
    push({tag, "_sw"},  e + 2, {5'b11000, t});
    push({tag, "_off"}, e + 5, {5'b11001, t});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e;
    int c;
    rstn = 1'b0;
    power = 1'b0;
    ack_force_en = 1'b0;
    ack_force_val = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vec", {26'd0, vec}, 32'h30);
    mon_en = 1'b1;

    @(negedge clk);
    rstn = 1'b1;
    push("off_done", cyc + 1, 6'b110010);
    wait_until(cyc + 3);

    // Power-up with instant ring echo.
    drive_power(1'b1, e);
    push("up_send", e,     6'b010000);
    push("up_clk",  e + 3, 6'b011000);
    push("up_rst",  e + 7, 6'b011100);
    push("up_on",   e + 9, 6'b001110);
    wait_until(e + 12);

    drive_power(1'b0, e);
    expect_power_down("dn", e, 1'b0);
    wait_until(e + 8);

    // Request withdrawn one cycle after power-up starts: no abort.
    drive_power(1'b1, e);
    push("tg_send", e,      6'b010000);
    push("tg_clk",  e + 3,  6'b011000);
    push("tg_rst",  e + 7,  6'b011100);
    push("tg_on",   e + 9,  6'b001100);
    drive_power(1'b0, c);
    expect_power_down("tg_dn", e + 10, 1'b0);
    wait_until(e + 18);

    // Synchronous reset pulse while in RST_REL, request held high.
    drive_power(1'b1, e);
    push("mr_send",  e,      6'b010000);
    push("mr_clk",   e + 3,  6'b011000);
    push("mr_rst",   e + 7,  6'b011100);
    push("mr_reset", e + 8,  6'b110000);
    push("mr_send2", e + 9,  6'b010000);
    push("mr_clk2",  e + 12, 6'b011000);
    push("mr_rst2",  e + 16, 6'b011100);
    push("mr_on2",   e + 18, 6'b001110);
    wait_until(e + 7);
    rstn = 1'b0;
    wait_until(e + 8);
    rstn = 1'b1;
    wait_until(e + 21);
    drive_power(1'b0, e);
    expect_power_down("mr_dn", e, 1'b0);
    wait_until(e + 8);

    // Ring echo stuck at 1 during power-up.
    @(negedge clk);
    ack_force_val = 1'b1;
    ack_force_en  = 1'b1;
`ifdef PD_ACK_TIMEOUT_EN
    drive_power(1'b1, e);
    push("to_send", e,      6'b010000);
    push("to_clk",  e + 64, 6'b011001);
    push("to_rst",  e + 68, 6'b011101);
    push("to_on",   e + 70, 6'b001111);
    wait_until(e + 73);
    drive_power(1'b0, e);
    push("to_dn_iso", e,     6'b011101);
    push("to_dn_sw",  e + 2, 6'b110001);
    push("to_dn_off", e + 3, 6'b110011);
    wait_until(e + 6);
    check("to_sticky", {31'd0, timeout}, 32'd1);
    ack_force_en = 1'b0;
`else
    drive_power(1'b1, e);
    push("st_send", e, 6'b010000);
    wait_until(e + 1000);
    check("st_timeout", {31'd0, timeout}, 32'd0);
    check("st_clk_en",  {31'd0, clk_en},  32'd0);
    ack_force_en = 1'b0;
    c = cyc;
    push("st_clk", c + 3, 6'b011000);
    push("st_rst", c + 7, 6'b011100);
    push("st_on",  c + 9, 6'b001110);
    wait_until(c + 12);
    drive_power(1'b0, e);
    expect_power_down("st_dn", e, 1'b0);
    wait_until(e + 8);
`endif

    wait_until(cyc + 5);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
